fft_frame_source: RTL and testbench

// Transmit side of the FFT IP streaming sink interface (ready latency 0). Accepts a continuous

---
 rtl/fft_frame_source.sv | 161 ++++++++++++++++
 tb/tb_fft_frame_source.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_source.sv
// Frames a continuous complex sample stream into FFT_LEN-sample packets with sop/eop markers
// for the FFT sink port. It uses an output register plus a one-entry skid buffer, so in_ready is registered.
module fft_frame_source #(
    parameter int FFT_LEN = 65536,
    parameter int DATA_W  = 16,
    parameter int IDX_W   = $clog2(FFT_LEN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     cfg_inverse,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_real,
    input  logic signed [DATA_W-1:0] in_imag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic signed [DATA_W-1:0] out_real,
    output logic signed [DATA_W-1:0] out_imag,
    output logic                     out_inverse,
    output logic [1:0]               out_error,
    output logic [IDX_W-1:0]         sample_idx,
    output logic [15:0]              frames_done,
    output logic                     busy
);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_LEN - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic                       r_in_ready;
    logic                       r_out_valid;
    logic signed [DATA_W-1:0]   r_out_real;
    logic signed [DATA_W-1:0]   r_out_imag;
    logic                       r_out_inverse;
    logic                       r_skid_full;
    logic signed [DATA_W-1:0]   r_skid_real;
    logic signed [DATA_W-1:0]   r_skid_imag;
    logic [IDX_W-1:0]           r_idx;
    logic [IDX_W-1:0]           r_in_cnt;
    logic [15:0]                r_frames;

    logic                       w_accept;
    logic                       w_out_xfer;
    logic                       w_last_out;
    logic                       w_out_load_en;
    logic                       w_frame_active;
    logic                       w_skid_full_nxt;
    logic [IDX_W-1:0]           w_in_cnt_nxt;
    logic [IDX_W-1:0]           w_load_idx;
    logic                       w_load_new;
    logic                       w_in_ready_nxt;

    assign w_accept       = in_valid && r_in_ready;
    assign w_out_xfer     = r_out_valid && out_ready;
    assign w_last_out     = (r_idx == LAST_IDX);
    assign w_out_load_en  = !r_out_valid || out_ready;
    assign w_frame_active = r_out_valid || r_skid_full || (r_idx != '0) || (r_in_cnt != '0);
    assign w_skid_full_nxt = w_out_load_en ? (r_skid_full && w_accept) : (r_skid_full || w_accept);
    assign w_in_cnt_nxt   = w_accept ? (r_in_cnt + ONE_IDX) : r_in_cnt;
    // Index of the sample entering the output register this cycle.
    assign w_load_idx     = w_out_xfer ? (r_idx + ONE_IDX) : r_idx;
    assign w_load_new     = w_out_load_en && (r_skid_full || w_accept);
    // While draining, stop accepting once the final sample of the frame is in (input count wrapped).
    assign w_in_ready_nxt = !w_skid_full_nxt &&
                            ((w_state_nxt == S_STREAM) ||
                             ((w_state_nxt == S_DRAIN) && (w_in_cnt_nxt != '0)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (en) w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (!en) begin
                    if (w_out_xfer && w_last_out && !w_accept && !r_skid_full && (r_in_cnt == '0))
                        w_state_nxt = S_IDLE;
                    else if (w_frame_active || w_accept)
                        w_state_nxt = S_DRAIN;
                    else
                        w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (en)
                    w_state_nxt = S_STREAM;
                else if (w_out_xfer && w_last_out && !r_skid_full && (r_in_cnt == '0))
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_real    <= '0;
            r_out_imag    <= '0;
            r_out_inverse <= 1'b0;
            r_skid_full   <= 1'b0;
            r_idx         <= '0;
            r_in_cnt      <= '0;
            r_frames      <= '0;
        end else begin
            r_in_ready  <= w_in_ready_nxt;
            r_skid_full <= w_skid_full_nxt;
            r_in_cnt    <= w_in_cnt_nxt;
            if (w_out_xfer) begin
                r_idx <= r_idx + ONE_IDX;
                if (w_last_out) r_frames <= r_frames + 16'd1;
            end
            if (w_out_load_en) begin
                r_out_valid <= r_skid_full || w_accept;
                if (r_skid_full) begin
                    r_out_real <= r_skid_real;
                    r_out_imag <= r_skid_imag;
                end else if (w_accept) begin
                    r_out_real <= in_real;
                    r_out_imag <= in_imag;
                end
                if (w_load_new && (w_load_idx == '0)) r_out_inverse <= cfg_inverse;
            end
        end
    end

    // Skid data needs no reset: it is only ever read while r_skid_full is set.
    always_ff @(posedge clk) begin
        if (w_accept && (r_skid_full || !w_out_load_en)) begin
            r_skid_real <= in_real;
            r_skid_imag <= in_imag;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_real    = r_out_real;
    assign out_imag    = r_out_imag;
    assign out_inverse = r_out_inverse;
    assign out_sop     = r_out_valid && (r_idx == '0);
    assign out_eop     = r_out_valid && w_last_out;
    assign out_error   = 2'b00;
    assign sample_idx  = r_idx;
    assign frames_done = r_frames;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_fft_frame_source.sv
// Directed bench for fft_frame_source: small-frame instance (FFT_LEN=8) for framing, backpressure,
// drain, direction and reset cases, plus a full-size instance for the 65536-sample wrap.
module tb_fft_frame_source;
    localparam int LEN = 8;
    localparam int IW  = 3;
    localparam int BIG = 65536;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, en, cfg_inverse, in_valid, in_ready, out_valid, out_ready;
    logic               out_sop, out_eop, out_inverse, busy;
    logic signed [15:0] in_real, in_imag, out_real, out_imag;
    logic [1:0]         out_error;
    logic [IW-1:0]      sample_idx;
    logic [15:0]        frames_done;

    logic               b_en, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic               b_out_sop, b_out_eop, b_out_inverse, b_busy;
    logic signed [15:0] b_in_real, b_in_imag, b_out_real, b_out_imag;
    logic [1:0]         b_out_error;
    logic [15:0]        b_sample_idx, b_frames_done;

    fft_frame_source #(.FFT_LEN(LEN), .DATA_W(16)) u_dut (
        .clk(clk), .rst(rst), .en(en), .cfg_inverse(cfg_inverse),
        .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
        .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
        .out_real(out_real), .out_imag(out_imag), .out_inverse(out_inverse),
        .out_error(out_error), .sample_idx(sample_idx), .frames_done(frames_done), .busy(busy)
    );

    fft_frame_source #(.FFT_LEN(BIG), .DATA_W(16)) u_big (
        .clk(clk), .rst(rst), .en(b_en), .cfg_inverse(1'b0),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_real(b_in_real), .in_imag(b_in_imag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sop(b_out_sop), .out_eop(b_out_eop),
        .out_real(b_out_real), .out_imag(b_out_imag), .out_inverse(b_out_inverse),
        .out_error(b_out_error), .sample_idx(b_sample_idx), .frames_done(b_frames_done), .busy(b_busy)
    );

    typedef struct packed {
        logic [15:0]   re;
        logic [15:0]   im;
        logic          sop;
        logic          eop;
        logic          inv;
        logic [IW-1:0] idx;
    } xfer_t;

    xfer_t       q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          max_inflight = 0;
    logic [31:0] mask = 32'hB3C6_59A5;

    int b_xfer = 0, b_data_err = 0, b_eop_cnt = 0, b_sop_cnt = 0;
    int b_eop_pos = -1, b_sop2_pos = -1, b_idx_last = -1, b_idx_wrap = -1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid && out_ready)
            q.push_back({out_real, out_imag, out_sop, out_eop, out_inverse, sample_idx});
    end

    always @(negedge clk) begin
        if (b_out_valid && b_out_ready) begin
            if (b_out_real !== 16'(b_xfer) || b_out_imag !== 16'(0) || b_out_error !== 2'b00)
                b_data_err++;
            if (b_out_sop) begin
                b_sop_cnt++;
                if (b_xfer != 0) b_sop2_pos = b_xfer;
            end
            if (b_out_eop) begin
                b_eop_cnt++;
                b_eop_pos = b_xfer;
            end
            if (b_xfer == BIG - 1) b_idx_last = int'(b_sample_idx);
            if (b_xfer == BIG)     b_idx_wrap = int'(b_sample_idx);
            b_xfer++;
        end
    end

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; cfg_inverse = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_real = '0; in_imag = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
    endtask

    task automatic run_stream(input int n, input int base, input bit rnd,
                              input int flip_at, input int stop_at);
        int          sent = 0;
        int          cyc = 0;
        bit          acc, stall;
        bit          first = 1'b1;
        logic [63:0] snap;
        in_valid = 1'b1;
        in_real  = 16'(base);
        in_imag  = 16'(256 + base);
        while (sent < n && cyc < 500) begin
            @(negedge clk);
            acc   = in_valid && in_ready;
            stall = out_valid && !out_ready;
            snap  = 64'({out_valid, out_real, out_imag, out_sop, out_eop, out_inverse, sample_idx});
            @(posedge clk);
            #1;
            cyc++;
            if (stall)
                check_eq("hold", 64'({out_valid, out_real, out_imag, out_sop, out_eop, out_inverse, sample_idx}), snap);
            if (acc) begin
                if (first) begin
                    check_eq("latency", 64'({out_valid, out_real}), 64'({1'b1, 16'(base)}));
                    first = 1'b0;
                end
                sent++;
                in_real = 16'(base + sent);
                in_imag = 16'(256 + base + sent);
                if (sent == flip_at) cfg_inverse = ~cfg_inverse;
                if (sent == stop_at) en = 1'b0;
            end
            if (sent == n) in_valid = 1'b0;
            out_ready = rnd ? mask[cyc % 32] : 1'b1;
            if (sent - q.size() > max_inflight) max_inflight = sent - q.size();
        end
        if (sent < n) check_eq("in_timeout", 64'(sent), 64'(n));
        in_valid = 1'b0;
    endtask

    task automatic wait_q(input int n);
        int cyc = 0;
        out_ready = 1'b1;
        while (q.size() < n && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("xfer_count", 64'(q.size()), 64'(n));
    endtask

    task automatic verify_q(input int n, input int base, input int inv_from);
        xfer_t e;
        for (int k = 0; k < n && k < q.size(); k++) begin
            e.re  = 16'(base + k);
            e.im  = 16'(256 + base + k);
            e.sop = (k % LEN == 0);
            e.eop = (k % LEN == LEN - 1);
            e.inv = (k >= inv_from);
            e.idx = IW'(k % LEN);
            check_eq($sformatf("xfer%0d", k), 64'(q[k]), 64'(e));
        end
    endtask

    initial begin
        int  acc_cnt, ov_cnt, cyc, b_sent;
        bit  acc;
        b_en = 1'b0; b_in_valid = 1'b0; b_in_real = '0; b_in_imag = '0; b_out_ready = 1'b1;
        do_reset();
        check_eq("rst_state", 64'({out_valid, in_ready, out_sop, out_eop, out_inverse, busy, out_error,
                                   sample_idx, frames_done, out_real, out_imag}), 64'(0));

        // Two back-to-back frames of a ramp, no backpressure
        en = 1'b1;
        run_stream(16, 0, 1'b0, 0, 0);
        check_eq("busy_stream", 64'(busy), 64'(1));
        wait_q(16);
        verify_q(16, 0, 99);
        check_eq("frames_t1", 64'(frames_done), 64'(2));

        // Random-looking backpressure mask
        do_reset();
        en = 1'b1;
        max_inflight = 0;
        run_stream(24, 32, 1'b1, 0, 0);
        wait_q(24);
        verify_q(24, 32, 99);
        check_eq("skid_depth", 64'(max_inflight), 64'(2));
        check_eq("frames_t2", 64'(frames_done), 64'(3));

        // en dropped after sample 3: rest of frame drains, then idle
        do_reset();
        en = 1'b1;
        run_stream(8, 64, 1'b0, 0, 4);
        wait_q(8);
        verify_q(8, 64, 99);
        check_eq("drain_idle", 64'({busy, in_ready}), 64'(0));
        check_eq("frames_t3", 64'(frames_done), 64'(1));
        acc_cnt = 0; ov_cnt = 0;
        in_valid = 1'b1; in_real = 16'(99);
        repeat (10) begin
            @(negedge clk);
            if (in_ready) acc_cnt++;
            if (out_valid) ov_cnt++;
        end
        in_valid = 1'b0;
        check_eq("post_drain_acc", 64'(acc_cnt), 64'(0));
        check_eq("post_drain_valid", 64'(ov_cnt), 64'(0));

        // Direction flip mid-frame takes effect at next sop
        do_reset();
        en = 1'b1;
        run_stream(16, 96, 1'b0, 4, 0);
        wait_q(16);
        verify_q(16, 96, 8);

        // Reset mid-frame after sample 5, then restart
        do_reset();
        en = 1'b1;
        run_stream(6, 128, 1'b0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_mid", 64'({out_valid, in_ready, out_sop, out_eop, out_inverse, busy, out_error,
                                 sample_idx, frames_done, out_real, out_imag}), 64'(0));
        rst = 1'b0;
        q.delete();
        run_stream(8, 160, 1'b0, 0, 0);
        wait_q(8);
        verify_q(8, 160, 99);
        check_eq("frames_t5", 64'(frames_done), 64'(1));

        // Full-size frame: eop at 65535, index wrap, next sop
        en = 1'b0;
        b_en = 1'b1; b_in_valid = 1'b1; b_in_real = '0;
        b_sent = 0; cyc = 0;
        while (b_sent < BIG + 2 && cyc < 70000) begin
            @(negedge clk);
            acc = b_in_valid && b_in_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                b_sent++;
                b_in_real = 16'(b_sent);
            end
            if (b_sent == BIG + 2) b_in_valid = 1'b0;
        end
        repeat (4) @(posedge clk);
        #1;
        check_eq("big_xfers", 64'(b_xfer), 64'(BIG + 2));
        check_eq("big_data", 64'(b_data_err), 64'(0));
        check_eq("big_eop_cnt", 64'(b_eop_cnt), 64'(1));
        check_eq("big_eop_pos", 64'(b_eop_pos), 64'(BIG - 1));
        check_eq("big_sop_cnt", 64'(b_sop_cnt), 64'(2));
        check_eq("big_sop2_pos", 64'(b_sop2_pos), 64'(BIG));
        check_eq("big_idx_last", 64'(b_idx_last), 64'(BIG - 1));
        check_eq("big_idx_wrap", 64'(b_idx_wrap), 64'(0));
        check_eq("big_frames", 64'(b_frames_done), 64'(1));
        check_eq("big_status", 64'({b_busy, b_out_inverse}), 64'(2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
